// File: rtl/fir_filter.sv
// Serial-MAC FIR filter: coefficients loaded serially after reset, then one
// TAPS-cycle convolution per accepted sample, result emitted as a one-cycle pulse.
module fir_filter #(
    parameter int unsigned TAPS = 16,
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coef_valid,
    input  logic [CW-1:0] coef_d,
    input  logic          data_valid,
    input  logic [DW-1:0] data_d,
    output logic          data_ready,
    output logic          fir_valid,
    output logic [DW-1:0] fir_d
);

    localparam int unsigned IW = $clog2(TAPS);
    localparam int unsigned PW = DW + CW;
    localparam int unsigned AW = DW + CW + $clog2(TAPS);

    localparam logic signed [AW-1:0] RND_BIAS = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic                 load_c;
    logic                 accept_c;
    logic                 mac_c;
    logic                 mac_last_c;

    logic [IW-1:0]        idx;
    logic [IW-1:0]        tap;
    logic signed [CW-1:0] coef [TAPS];
    logic signed [DW-1:0] hist [TAPS];
    logic signed [AW-1:0] acc;

    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] acc_sum_c;
    logic signed [AW-1:0] biased_c;
    logic signed [AW-1:0] shifted_c;
    logic [DW-1:0]        result_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath enables
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        accept_c   = 1'b0;
        mac_c      = 1'b0;
        mac_last_c = 1'b0;
        case (state)
            S_LOAD: begin
                if (coef_valid) begin
                    load_c = 1'b1;
                    if (idx == IW'(TAPS - 1)) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (data_valid) begin
                    accept_c   = 1'b1;
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                mac_c = 1'b1;
                if (tap == IW'(TAPS - 1)) begin
                    mac_last_c = 1'b1;
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    // One tap per cycle; the final sum is rounded and clamped on the last MAC cycle
    always_comb begin
        prod_c    = PW'(coef[tap]) * PW'(hist[tap]);
        acc_sum_c = acc + AW'(prod_c);
        biased_c  = acc_sum_c + RND_BIAS;
        shifted_c = biased_c >>> FRAC;
        if (shifted_c > SAT_MAX) begin
            result_c = SAT_MAX[DW-1:0];
        end else if (shifted_c < SAT_MIN) begin
            result_c = SAT_MIN[DW-1:0];
        end else begin
            result_c = shifted_c[DW-1:0];
        end
    end

    // Coefficient store, sample history, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            tap        <= '0;
            acc        <= '0;
            data_ready <= 1'b0;
            fir_valid  <= 1'b0;
            fir_d      <= '0;
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
                hist[k] <= '0;
            end
        end else begin
            data_ready <= (state_next == S_IDLE);
            fir_valid  <= 1'b0;
            if (load_c) begin
                coef[idx] <= coef_d;
                idx       <= idx + IW'(1);
            end
            if (accept_c) begin
                hist[0] <= data_d;
                for (int k = 1; k < TAPS; k++) begin
                    hist[k] <= hist[k-1];
                end
                tap <= '0;
                acc <= '0;
            end
            if (mac_c) begin
                acc <= acc_sum_c;
                tap <= tap + IW'(1);
            end
            if (mac_last_c) begin
                fir_d     <= result_c;
                fir_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: vector table, hand-written timing/reset
// sequences and randomized samples against a convolution reference model.
module tb_fir_filter;

    localparam int unsigned TAPS = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 16;
    localparam int unsigned FRAC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          coef_valid;
    logic [CW-1:0] coef_d;
    logic          data_valid;
    logic [DW-1:0] data_d;
    logic          data_ready;
    logic          fir_valid;
    logic [DW-1:0] fir_d;

    int n_vec = 0;
    int n_err = 0;
    longint cyc = 0;

    longint mc [TAPS];
    longint mh [TAPS];
    longint cset [TAPS];

    typedef struct {
        longint c0;
        longint x;
        longint y;
    } vec_t;
    vec_t vecs [9];

    fir_filter #(.TAPS(TAPS), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_valid (coef_valid),
        .coef_d     (coef_d),
        .data_valid (data_valid),
        .data_d     (data_d),
        .data_ready (data_ready),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // fir_valid must never be high on two consecutive cycles
    logic prev_fv = 1'b0;
    always @(posedge clk) begin
        #1;
        if (fir_valid) check("fir_valid_single_cycle", longint'(prev_fv), 0);
        prev_fv = fir_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint fir_out();
        return longint'($signed(fir_d));
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) begin
            mc[k] = 0;
            mh[k] = 0;
        end
    endfunction

    // y[n] = sum c[k]*x[n-k], rounded half-up at FRAC bits, clamped to DW signed
    function automatic longint model_push(input longint x);
        longint acc;
        longint y;
        longint hi;
        longint lo;
        for (int k = TAPS - 1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = x;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += mc[k] * mh[k];
        y  = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y;
    endfunction

    task automatic do_reset();
        rst        = 1'b0;
        coef_valid = 1'b0;
        data_valid = 1'b0;
        coef_d     = '0;
        data_d     = '0;
        step();
        step();
        check("reset_data_ready", longint'(data_ready), 0);
        check("reset_fir_valid", longint'(fir_valid), 0);
        check("reset_fir_d", fir_out(), 0);
        rst = 1'b1;
        model_clear();
        step();
    endtask

    // Loads cset[] with random gaps and random data_valid noise (must be ignored)
    task automatic load_coefs();
        for (int i = 0; i < TAPS; i++) begin
            coef_valid = 1'b1;
            coef_d     = CW'(cset[i]);
            data_valid = 1'($urandom_range(0, 1));
            data_d     = DW'($urandom);
            step();
            coef_valid = 1'b0;
            data_valid = 1'b0;
            mc[i]      = cset[i];
            if (i == TAPS - 1) begin
                check("ready_after_load", longint'(data_ready), 1);
            end else begin
                check("ready_during_load", longint'(data_ready), 0);
                if ($urandom_range(0, 2) == 0) begin
                    step();
                    check("ready_load_gap", longint'(data_ready), 0);
                end
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!data_ready && n < 100) begin
            step();
            n++;
        end
        if (!data_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input longint x, input string name);
        longint exp;
        int lat;
        wait_ready();
        data_valid = 1'b1;
        data_d     = DW'(x);
        step();
        data_valid = 1'b0;
        exp = model_push(x);
        lat = 1;
        while (!fir_valid && lat < TAPS + 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, longint'(lat), longint'(TAPS + 1));
        check(name, fir_out(), exp);
    endtask

    task automatic set_single(input longint c0);
        for (int k = 0; k < TAPS; k++) cset[k] = (k == 0) ? c0 : 0;
    endtask

    task automatic set_all(input longint c);
        for (int k = 0; k < TAPS; k++) cset[k] = c;
    endtask

    initial begin
        longint exp;
        longint last_cyc;
        int n;

        vecs[0] = '{c0: 256,   x: 100,    y: 100};
        vecs[1] = '{c0: -256,  x: 100,    y: -100};
        vecs[2] = '{c0: 32767, x: 32767,  y: 32767};
        vecs[3] = '{c0: 32767, x: -32768, y: -32768};
        vecs[4] = '{c0: 1,     x: 128,    y: 1};
        vecs[5] = '{c0: 1,     x: 127,    y: 0};
        vecs[6] = '{c0: 1,     x: -128,   y: 0};
        vecs[7] = '{c0: 1,     x: -129,   y: -1};
        vecs[8] = '{c0: 16,    x: 1600,   y: 100};

        rst = 1'b0;
        coef_valid = 1'b0;
        data_valid = 1'b0;
        coef_d = '0;
        data_d = '0;

        // Single-coefficient vectors: saturation, rounding, sign
        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_single(vecs[i].c0);
            load_coefs();
            wait_ready();
            data_valid = 1'b1;
            data_d     = DW'(vecs[i].x);
            step();
            data_valid = 1'b0;
            n = 1;
            while (!fir_valid && n < TAPS + 20) begin
                step();
                n++;
            end
            check($sformatf("vec%0d_latency", i), longint'(n), longint'(TAPS + 1));
            check($sformatf("vec%0d_fir_d", i), fir_out(), vecs[i].y);
        end

        // Impulse: cycle-exact latency and ready recovery
        do_reset();
        set_single(256);
        load_coefs();
        wait_ready();
        data_valid = 1'b1;
        data_d     = DW'(100);
        step();
        data_valid = 1'b0;
        exp = model_push(100);
        for (int k = 1; k <= TAPS; k++) begin
            check("impulse_quiet_valid", longint'(fir_valid), 0);
            check("impulse_busy_ready", longint'(data_ready), 0);
            step();
        end
        check("impulse_valid_t17", longint'(fir_valid), 1);
        check("impulse_fir_d", fir_out(), 100);
        check("impulse_ready_t17", longint'(data_ready), 0);
        step();
        check("impulse_valid_t18", longint'(fir_valid), 0);
        check("impulse_ready_t18", longint'(data_ready), 1);
        check("impulse_fir_d_held", fir_out(), exp);

        // Averaging with data_valid held high
        do_reset();
        set_all(16);
        load_coefs();
        data_valid = 1'b1;
        data_d     = DW'(1600);
        last_cyc   = 0;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!fir_valid && n < 60);
            if (i == 19) data_valid = 1'b0;
            exp = model_push(1600);
            check($sformatf("avg_%0d", i), fir_out(), exp);
            check($sformatf("avg_expect_%0d", i), fir_out(), (i < 16) ? 100 * (i + 1) : 1600);
            if (i > 0) check("avg_spacing", cyc - last_cyc, longint'(TAPS + 2));
            last_cyc = cyc;
        end
        step();
        step();
        check("avg_no_extra_accept", longint'(data_ready), 1);

        // Randomized coefficients and samples
        do_reset();
        for (int k = 0; k < TAPS; k++) cset[k] = longint'($urandom_range(0, 1200)) - 600;
        load_coefs();
        for (int i = 0; i < 24; i++) begin
            n = int'($urandom_range(0, 3));
            for (int g = 0; g < n; g++) step();
            send(longint'($urandom_range(0, 65535)) - 32768, "rand");
        end

        // Reset mid-MAC: no pulse for the aborted sample, history and coefs cleared
        do_reset();
        set_all(256);
        load_coefs();
        send(1000, "premac");
        wait_ready();
        data_valid = 1'b1;
        data_d     = DW'(50);
        step();
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b0;
        #1;
        check("midmac_async_ready", longint'(data_ready), 0);
        check("midmac_async_valid", longint'(fir_valid), 0);
        check("midmac_async_fir_d", fir_out(), 0);
        for (int k = 0; k < 20; k++) begin
            step();
            check("midmac_no_pulse", longint'(fir_valid), 0);
        end
        rst = 1'b1;
        model_clear();
        step();
        check("midmac_ready_low", longint'(data_ready), 0);
        load_coefs();
        send(7, "after_midmac");
        check("after_midmac_literal", fir_out(), 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
